// File: rtl/round_robin_pkg.sv
// Shared sizes and types for the slot-table round-robin arbiter.
package round_robin_pkg;
  localparam int NUM_REQ   = 4;
  localparam int NUM_SLOTS = 16;
  localparam int ID_W      = 2;
  localparam int PTR_W     = 4;

  typedef logic [ID_W-1:0]  slot_id_t;
  typedef logic [PTR_W-1:0] slot_ptr_t;
endpackage

// File: rtl/rr_slot_finder.sv
// Combinational search for the winning slot starting at ptr; ROUND_ROBIN_SCAN_EN selects
// a full wrapping scan, otherwise only slot ptr is examined (strict TDM).
module rr_slot_finder
  import round_robin_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] eligible,
  input  slot_ptr_t            ptr,
  output logic                 found,
  output slot_ptr_t            win_slot
);

`ifdef ROUND_ROBIN_SCAN_EN
  slot_ptr_t idx;

  // Walk offsets from farthest to nearest so the closest eligible slot is the last write.
  always_comb begin
    found    = 1'b0;
    win_slot = ptr;
    idx      = ptr;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (eligible[idx]) begin
        found    = 1'b1;
        win_slot = idx;
      end
    end
  end
`else
  always_comb begin
    found    = eligible[ptr];
    win_slot = ptr;
  end
`endif

endmodule

// File: rtl/round_robin.sv
// Weighted round-robin arbiter over a 16-entry slot table; registered grant one edge after req.
// Optional ROUND_ROBIN_SCAN_EN: full scan from ptr; undefined: strict TDM, ptr advances every cycle.
module round_robin
  import round_robin_pkg::*;
#(
  parameter slot_id_t IDLE_ID = 2'b00
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req0,
  input  logic     req1,
  input  logic     req2,
  input  logic     req3,
  input  slot_id_t p0,
  input  slot_id_t p1,
  input  slot_id_t p2,
  input  slot_id_t p3,
  input  slot_id_t p4,
  input  slot_id_t p5,
  input  slot_id_t p6,
  input  slot_id_t p7,
  input  slot_id_t p8,
  input  slot_id_t p9,
  input  slot_id_t p10,
  input  slot_id_t p11,
  input  slot_id_t p12,
  input  slot_id_t p13,
  input  slot_id_t p14,
  input  slot_id_t p15,
  output logic     valid,
  output slot_id_t out_id
);

  slot_id_t             tbl [NUM_SLOTS];
  logic [NUM_REQ-1:0]   req_vec;
  logic [NUM_SLOTS-1:0] eligible;
  logic                 found;
  slot_ptr_t            win_slot;

  slot_ptr_t ptr_q, ptr_d;
  logic      valid_q, valid_d;
  slot_id_t  out_id_q, out_id_d;

  assign tbl = '{p0, p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15};
  assign req_vec = {req3, req2, req1, req0};

  always_comb begin
    eligible = '0;
    for (int n = 0; n < NUM_SLOTS; n++) begin
      eligible[n] = req_vec[tbl[n]];
    end
  end

  rr_slot_finder u_finder (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (found),
    .win_slot (win_slot)
  );

  always_comb begin
    ptr_d    = ptr_q;
    valid_d  = 1'b0;
    out_id_d = IDLE_ID;
    if (found) begin
      valid_d  = 1'b1;
      out_id_d = tbl[win_slot];
    end
`ifdef ROUND_ROBIN_SCAN_EN
    if (found) begin
      ptr_d = win_slot + PTR_W'(1);
    end
`else
    ptr_d = ptr_q + PTR_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      out_id_q <= IDLE_ID;
    end else begin
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      out_id_q <= out_id_d;
    end
  end

  assign valid  = valid_q;
  assign out_id = out_id_q;

endmodule

// File: tb/tb_round_robin.sv
// Directed bench for round_robin; expectations follow the build's ROUND_ROBIN_SCAN_EN setting.
module tb_round_robin;
  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] p [16];
  logic       valid;
  logic [1:0] out_id;

  int total = 0;
  int bad   = 0;

  round_robin #(.IDLE_ID(2'b00)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
    .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
    .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
    .p8(p[8]), .p9(p[9]), .p10(p[10]), .p11(p[11]),
    .p12(p[12]), .p13(p[13]), .p14(p[14]), .p15(p[15]),
    .valid(valid), .out_id(out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (valid !== 1'b0 || out_id !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold c%0d: got valid=%b id=%0d want valid=0 id=0", c, valid, out_id);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (valid !== 1'b0 || out_id !== 2'd0) begin
        bad++;
        $display("FAIL idle_after_reset c%0d: got valid=%b id=%0d want valid=0 id=0", c, valid, out_id);
      end
    end
  endtask

`ifdef ROUND_ROBIN_SCAN_EN
  task automatic test_req0_only();
    logic [3:0] exp_ptr [6];
    exp_ptr = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd0, 4'd1};
    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (valid !== 1'b1 || out_id !== 2'd0 || dut.ptr_q !== exp_ptr[c]) begin
        bad++;
        $display("FAIL req0_scan c%0d: got valid=%b id=%0d ptr=%0d want valid=1 id=0 ptr=%0d",
                 c, valid, out_id, dut.ptr_q, exp_ptr[c]);
      end
    end
  endtask

  task automatic test_req2_only();
    logic [3:0] exp_ptr [4];
    exp_ptr = '{4'd6, 4'd13, 4'd14, 4'd6};
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (valid !== 1'b1 || out_id !== 2'd2 || dut.ptr_q !== exp_ptr[c]) begin
        bad++;
        $display("FAIL req2_scan c%0d: got valid=%b id=%0d ptr=%0d want valid=1 id=2 ptr=%0d",
                 c, valid, out_id, dut.ptr_q, exp_ptr[c]);
      end
    end
  endtask

  task automatic test_weighted();
    logic [1:0] exp_id [9];
    exp_id = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd3};
    req = 4'b0000;
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 9; c++) begin
      step();
      total++;
      if (valid !== 1'b1 || out_id !== exp_id[c]) begin
        bad++;
        $display("FAIL weighted c%0d: got valid=%b id=%0d want valid=1 id=%0d", c, valid, out_id, exp_id[c]);
      end
    end
  endtask

  task automatic test_mid_reset();
    req = 4'b0000;
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 4; c++) step();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (valid !== 1'b0 || out_id !== 2'd0 || dut.ptr_q !== 4'd0) begin
        bad++;
        $display("FAIL mid_reset c%0d: got valid=%b id=%0d ptr=%0d want valid=0 id=0 ptr=0",
                 c, valid, out_id, dut.ptr_q);
      end
    end
    reset = 1'b1;
    req   = 4'b1000;
    step();
    total++;
    if (valid !== 1'b1 || out_id !== 2'd3 || dut.ptr_q !== 4'd4) begin
      bad++;
      $display("FAIL post_reset_first: got valid=%b id=%0d ptr=%0d want valid=1 id=3 ptr=4", valid, out_id, dut.ptr_q);
    end
    step();
    total++;
    if (valid !== 1'b1 || out_id !== 2'd3 || dut.ptr_q !== 4'd9) begin
      bad++;
      $display("FAIL post_reset_second: got valid=%b id=%0d ptr=%0d want valid=1 id=3 ptr=9", valid, out_id, dut.ptr_q);
    end
  endtask
`else
  task automatic test_tdm_req0();
    logic [15:0] exp_v;
    exp_v = 16'b1000_1000_0000_0111;  // bit N = slot N owned by requester 0
    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 32; c++) begin
      step();
      total++;
      if (valid !== exp_v[c % 16] || out_id !== 2'd0) begin
        bad++;
        $display("FAIL tdm_req0 c%0d: got valid=%b id=%0d want valid=%b id=0", c, valid, out_id, exp_v[c % 16]);
      end
    end
  endtask

  task automatic test_tdm_mixed();
    logic       exp_v  [16];
    logic [1:0] exp_id [16];
    exp_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_id = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd1,
               2'd3, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    req = 4'b0000;
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 16; c++) begin
      step();
      total++;
      if (valid !== exp_v[c] || out_id !== exp_id[c]) begin
        bad++;
        $display("FAIL tdm_mixed c%0d: got valid=%b id=%0d want valid=%b id=%0d",
                 c, valid, out_id, exp_v[c], exp_id[c]);
      end
    end
  endtask

  task automatic test_tdm_mid_reset();
    logic       exp_v [4];
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b1};
    req = 4'b0000;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) step();
    reset = 1'b0;
    step();
    total++;
    if (valid !== 1'b0 || out_id !== 2'd0) begin
      bad++;
      $display("FAIL tdm_mid_reset: got valid=%b id=%0d want valid=0 id=0", valid, out_id);
    end
    reset = 1'b1;
    req   = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (valid !== exp_v[c] || (exp_v[c] && out_id !== 2'd3) || (!exp_v[c] && out_id !== 2'd0)) begin
        bad++;
        $display("FAIL tdm_restart c%0d: got valid=%b id=%0d want valid=%b", c, valid, out_id, exp_v[c]);
      end
    end
  endtask
`endif

  initial begin
    logic [1:0] tbl_init [16];
    tbl_init = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1,
                 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0};
    p     = tbl_init;
    req   = 4'b0000;
    reset = 1'b0;
    #2;
    test_reset();
`ifdef ROUND_ROBIN_SCAN_EN
    test_req0_only();
    test_req2_only();
    test_weighted();
    test_mid_reset();
`else
    test_tdm_req0();
    test_tdm_mixed();
    test_tdm_mid_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
